// File: rtl/bcd_pkg.sv
// Shared BCD definitions: controller state encoding and decimal digit constants.
// No logic; no latency.
// No flow control.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with decimal correction.
// Purely combinational, zero latency.
// No flow control.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] ad,
    input  logic [3:0] bd,
    input  logic       c,
    output logic [3:0] digit,
    output logic       carry
);

    logic [4:0] s;

    always_comb begin
        s     = {1'b0, ad} + {1'b0, bd} + {4'b0, c};
        digit = s[3:0];
        carry = 1'b0;
        // A binary sum of 10..19 wraps to 0..9 once 6 is added modulo 16.
        if (s > {1'b0, BCD_MAX}) begin
            digit = s[3:0] + BCD_CORR;
            carry = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Latency: done sampled DIGITS+1 edges after the start edge.
// No backpressure: start is ignored while busy, accepted again in IDLE or DONE.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_t          state, state_nxt;
    logic            accept;
    logic [W-1:0]    a_r, b_r, sum_r;
    logic            sub_r, carry_r, cout_r, invalid_r;
    logic [IW-1:0]   idx_r;
    logic            bad_in;
    logic [3:0]      ad, bd, bd_eff, dig;
    logic            dig_carry;

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > BCD_MAX || b[4*i +: 4] > BCD_MAX) begin
                bad_in = 1'b1;
            end
        end
    end

    // Subtraction is a + (nine's complement of b) + 1; carry-out means no borrow.
    always_comb begin
        ad     = a_r[4*idx_r +: 4];
        bd     = b_r[4*idx_r +: 4];
        bd_eff = sub_r ? (BCD_MAX - bd) : bd;
    end

    bcd_digit_add u_digit (
        .ad    (ad),
        .bd    (bd_eff),
        .c     (carry_r),
        .digit (dig),
        .carry (dig_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx_r == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            sub_r     <= 1'b0;
            carry_r   <= 1'b0;
            idx_r     <= '0;
            sum_r     <= '0;
            cout_r    <= 1'b0;
            invalid_r <= 1'b0;
        end else if (accept) begin
            a_r       <= a;
            b_r       <= b;
            sub_r     <= sub;
            carry_r   <= sub ? 1'b1 : cin;
            idx_r     <= '0;
            invalid_r <= bad_in;
            if (bad_in) begin
                sum_r <= '0;
            end
        end else if (state == RUN) begin
            if (!invalid_r) begin
                sum_r[4*idx_r +: 4] <= dig;
            end
            carry_r <= dig_carry;
            idx_r   <= idx_r + 1'b1;
            if (idx_r == LAST_IDX) begin
                cout_r <= invalid_r ? 1'b0 : dig_carry;
            end
        end
    end

    assign sum     = sum_r;
    assign cout    = cout_r;
    assign invalid = invalid_r;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized and directed scoreboard bench for bcd_serial_adder (DIGITS=4).
// Expected results come from decimal integer arithmetic on the operands.
module tb_bcd_serial_adder;

    localparam int D = 4;
    localparam longint PW = 10000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [4*D-1:0] a = '0, b = '0;
    logic          cin = 1'b0, sub = 1'b0;
    logic          busy, done, cout, invalid;
    logic [4*D-1:0] sum;

    typedef struct {
        logic [4*D-1:0] sum;
        logic           cout;
        logic           inv;
        int             dcyc;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    logic [4*D-1:0] last_sum = '0;
    logic           last_cout = 1'b0;
    logic           have_last = 1'b0;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint bcd2int(input logic [4*D-1:0] v);
        longint r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [4*D-1:0] int2bcd(input longint n);
        logic [4*D-1:0] v = '0;
        longint m = n;
        for (int i = 0; i < D; i++) begin
            v[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return v;
    endfunction

    function automatic logic has_bad(input logic [4*D-1:0] v);
        logic r = 1'b0;
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    task automatic push_exp(input logic [4*D-1:0] xa, input logic [4*D-1:0] xb,
                            input logic xcin, input logic xsub, input int e);
        exp_t x;
        longint va = bcd2int(xa), vb = bcd2int(xb), t;
        x.dcyc = e + D;
        x.inv  = has_bad(xa) || has_bad(xb);
        if (x.inv) begin
            x.sum = '0; x.cout = 1'b0;
        end else if (!xsub) begin
            t = va + vb + (xcin ? 1 : 0);
            x.cout = (t >= PW);
            x.sum  = int2bcd(t % PW);
        end else begin
            x.cout = (va >= vb);
            x.sum  = int2bcd((va - vb + PW) % PW);
        end
        q.push_back(x);
    endtask

    // Drive one request; returns the cycle number of the edge that sampled start.
    task automatic issue(input logic [4*D-1:0] xa, input logic [4*D-1:0] xb,
                         input logic xcin, input logic xsub, output int e);
        @(posedge clk); #1;
        a = xa; b = xb; cin = xcin; sub = xsub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = cyc;
    endtask

    task automatic run_op(input logic [4*D-1:0] xa, input logic [4*D-1:0] xb,
                          input logic xcin, input logic xsub);
        int e;
        issue(xa, xb, xcin, xsub, e);
        push_exp(xa, xb, xcin, xsub, e);
        wait_idle();
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || done) && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy || done) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: busy=%b done=%b after %0d cycles", busy, done, k);
        end
    endtask

    function automatic logic [4*D-1:0] gen_bcd(input logic bad);
        logic [4*D-1:0] v;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (bad) v[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    // Monitor: checks each done pulse against the scoreboard, and result stability while idle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_sum = '0; last_cout = 1'b0; have_last = 1'b1;
            end else if (done) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_done: got done=1, expected no pulse (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_timing", 64'(cyc), 64'(e.dcyc));
                    chk("sum", 64'(sum), 64'(e.sum));
                    chk("cout", 64'(cout), 64'(e.cout));
                    chk("invalid", 64'(invalid), 64'(e.inv));
                    last_sum = e.sum; last_cout = e.cout; have_last = 1'b1;
                end
            end else if (have_last && !busy && !start) begin
                chk("idle_sum_stable", 64'(sum), 64'(last_sum));
                chk("idle_cout_stable", 64'(cout), 64'(last_cout));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic bad;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_invalid", 64'(invalid), 64'(0));

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0999, 16'h0000, 1'b1, 1'b0);
        run_op(16'h5000, 16'h1234, 1'b0, 1'b1);
        run_op(16'h1234, 16'h5000, 1'b1, 1'b1);
        run_op(16'h12A4, 16'h0001, 1'b0, 1'b0);
        run_op(16'h9999, 16'h9999, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b0, 1'b1);

        // Start held through RUN with different operands, accepted again in DONE.
        issue(16'h4321, 16'h0789, 1'b1, 1'b0, e);
        push_exp(16'h4321, 16'h0789, 1'b1, 1'b0, e);
        a = 16'h0042; b = 16'h0777; cin = 1'b0; sub = 1'b1; start = 1'b1;
        repeat (D + 1) @(posedge clk);
        #1 start = 1'b0;
        push_exp(16'h0042, 16'h0777, 1'b0, 1'b1, cyc);
        wait_idle();

        // Reset two cycles into RUN aborts without a done pulse.
        issue(16'h2468, 16'h1357, 1'b0, 1'b0, e);
        repeat (1) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        repeat (D + 2) @(posedge clk);
        #1;
        run_op(16'h2468, 16'h1357, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [4*D-1:0] ra, rb;
            bad = ($urandom_range(0, 7) == 0);
            ra = gen_bcd(bad && $urandom_range(0, 1) == 0);
            rb = gen_bcd(bad);
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
